apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 16, APB address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase length in HCLK cycles (used only under APB_TIMEOUT_EN).
REQ-004 SHALL have one clock and a synchronous, active-high reset: HCLK  input  1  clock; HRESET  input  1  synchronous active-high reset.
REQ-005 SHALL have port PCLKEN  input  1  APB clock enable; APB phases advance only on cycles where it is high.
REQ-006 SHALL have port REQ  input  2  per-requester transfer request, bit i = requester i.
REQ-007 SHALL have port ADDR  input  2*ADDRWIDTH  packed addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH].
REQ-008 SHALL have port WRITE  input  2  per-requester direction, 1 = write.
REQ-009 SHALL have port WDATA  input  2*DATAWIDTH  packed write data.
REQ-010 SHALL have port DONE  output  2  one-HCLK completion pulse per requester.
REQ-011 SHALL have port RDATA  output  DATAWIDTH  read data, valid while any DONE bit is high.
REQ-012 SHALL have port ERR  output  1  error status, valid while any DONE bit is high.
REQ-013 SHALL have APB ports: PSEL o 1; PENABLE o 1; PADDR o ADDRWIDTH; PWRITE o 1; PWDATA o DATAWIDTH; PRDATA i DATAWIDTH; PREADY i 1; PSLVERR i 1; APBACTIVE o 1 (equals PSEL).

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-015 IDLE: with PCLKEN high and an eligible request, SHALL grant, latch ADDR/WRITE/WDATA of the winner into PADDR/PWRITE/PWDATA, and enter SETUP; otherwise stay IDLE.
REQ-016 Eligible = REQ[i] high and DONE[i] low in that cycle (prevents regrant on the completion cycle).
REQ-017 Arbitration SHALL be round-robin via pointer LAST (last granted index): a single eligible requester wins; when both are eligible, index != LAST wins; LAST updates on every grant.
REQ-018 SETUP: PSEL=1, PENABLE=0; on PCLKEN high SHALL enter ACCESS.
REQ-019 ACCESS: PSEL=1, PENABLE=1; on PCLKEN and PREADY both high SHALL capture PRDATA into RDATA (0 for writes), PSLVERR into ERR, pulse DONE[grant] for exactly one cycle, drop PSEL/PENABLE, and return to IDLE.
REQ-020 PADDR/PWRITE/PWDATA SHALL remain stable from SETUP through ACCESS completion; requester inputs are ignored after grant, including REQ deassertion.
REQ-021 Minimum transfer: 3 HCLK cycles from grant cycle to DONE with PCLKEN and PREADY held high; minimum one IDLE cycle between transfers.
REQ-022 PREADY low in ACCESS SHALL extend ACCESS indefinitely (except REQ-027).
REQ-023 Requesters SHALL hold REQ and request fields until their DONE; a REQ dropped before grant is never serviced.

Reset
REQ-024 On HRESET high at a HCLK edge SHALL set state IDLE, LAST=1 (requester 0 first priority), and PSEL, PENABLE, PADDR, PWRITE, PWDATA, DONE, RDATA, ERR, APBACTIVE all to 0.
REQ-025 Reset mid-transfer SHALL abort immediately: PSEL/PENABLE low on the next edge, no DONE for the aborted transfer.

Configuration
REQ-026 Macro APB_TIMEOUT_EN SHALL compile in an ACCESS-phase watchdog counter.
REQ-027 With APB_TIMEOUT_EN: counter clears on ACCESS entry and counts every HCLK cycle in ACCESS; when it reaches TIMEOUT_CYCLES without completion, the FSM SHALL end the transfer as in REQ-019 but with ERR=1 and RDATA=0.
REQ-028 Without APB_TIMEOUT_EN: no counter logic; ACCESS waits for PREADY forever; TIMEOUT_CYCLES is unused.

Verification
REQ-029 Single read: REQ=01, ADDR0=0x0010, PRDATA=0xDEADBEEF, PREADY=1, PCLKEN=1 -> PSEL high at cycles 1-2, PENABLE at cycle 2, DONE=01 at cycle 3, RDATA=0xDEADBEEF, ERR=0.
REQ-030 Contention: REQ=11 held after reset -> grant order 0,1,0,1; each DONE exactly one cycle; PADDR alternates ADDR0/ADDR1.
REQ-031 Wait states: PREADY low for 4 cycles in ACCESS, PSLVERR=1 on completion -> ACCESS lasts 5 cycles, PADDR/PWDATA stable, DONE with ERR=1.
REQ-032 PCLKEN toggling 1-0-1-0 during a write of WDATA1=0x12345678 -> phases advance only on PCLKEN=1 cycles; PWDATA=0x12345678 throughout; PWRITE=1.
REQ-033 HRESET asserted during ACCESS -> PSEL=0 next edge, DONE stays 00, next grant goes to requester 0.
REQ-034 With APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck low -> DONE after 8 ACCESS cycles with ERR=1, RDATA=0; without it, PSEL remains high.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port (IDLE/SETUP/ACCESS).
// Define APB_TIMEOUT_EN to add an ACCESS-phase watchdog bounded by TIMEOUT_CYCLES.
module apb_req_arbiter #(
   parameter int ADDRWIDTH      = 16,
   parameter int DATAWIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   PCLKEN,
   input  logic [1:0]             REQ,
   input  logic [2*ADDRWIDTH-1:0] ADDR,
   input  logic [1:0]             WRITE,
   input  logic [2*DATAWIDTH-1:0] WDATA,
   output logic [1:0]             DONE,
   output logic [DATAWIDTH-1:0]   RDATA,
   output logic                   ERR,
   output logic                   PSEL,
   output logic                   PENABLE,
   output logic [ADDRWIDTH-1:0]   PADDR,
   output logic                   PWRITE,
   output logic [DATAWIDTH-1:0]   PWDATA,
   input  logic [DATAWIDTH-1:0]   PRDATA,
   input  logic                   PREADY,
   input  logic                   PSLVERR,
   output logic                   APBACTIVE
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic                  r_last;
   logic                  r_gnt;
   logic                  r_psel;
   logic                  r_penable;
   logic [ADDRWIDTH-1:0]  r_paddr;
   logic                  r_pwrite;
   logic [DATAWIDTH-1:0]  r_pwdata;
   logic [1:0]            r_done;
   logic [DATAWIDTH-1:0]  r_rdata;
   logic                  r_err;

   logic [ADDRWIDTH-1:0]  w_addr  [2];
   logic [DATAWIDTH-1:0]  w_wdata [2];
   logic [1:0]            w_elig;
   logic                  w_win;
   logic                  w_grant;
   logic                  w_complete;
   logic                  w_timeout;
   logic                  w_finish;

   logic                  w_last_next;
   logic                  w_gnt_next;
   logic                  w_psel_next;
   logic                  w_penable_next;
   logic [ADDRWIDTH-1:0]  w_paddr_next;
   logic                  w_pwrite_next;
   logic [DATAWIDTH-1:0]  w_pwdata_next;
   logic [1:0]            w_done_next;
   logic [DATAWIDTH-1:0]  w_rdata_next;
   logic                  w_err_next;

   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_addr[gi]  = ADDR[gi*ADDRWIDTH +: ADDRWIDTH];
      assign w_wdata[gi] = WDATA[gi*DATAWIDTH +: DATAWIDTH];
   end

   // A requester whose DONE is high this cycle sits out so it cannot be regranted at once.
   assign w_elig     = REQ & ~r_done;
   assign w_win      = (w_elig == 2'b11) ? ~r_last : w_elig[1];
   assign w_grant    = (r_state == S_IDLE) && PCLKEN && (w_elig != 2'b00);
   assign w_complete = (r_state == S_ACCESS) && PCLKEN && PREADY;

`ifdef APB_TIMEOUT_EN
   localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WDOG_W-1:0] r_wdog;

   // Holds the number of ACCESS cycles already spent, so it is zero in the first one.
   always_ff @(posedge HCLK) begin
      if (HRESET || (r_state != S_ACCESS)) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + WDOG_W'(1);
      end
   end

   assign w_timeout = (r_state == S_ACCESS) && !w_complete &&
                      (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign w_timeout            = 1'b0;
`endif

   assign w_finish = w_complete || w_timeout;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state   <= S_IDLE;
         r_last    <= 1'b1;
         r_gnt     <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pwdata  <= '0;
         r_done    <= 2'b00;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_last    <= w_last_next;
         r_gnt     <= w_gnt_next;
         r_psel    <= w_psel_next;
         r_penable <= w_penable_next;
         r_paddr   <= w_paddr_next;
         r_pwrite  <= w_pwrite_next;
         r_pwdata  <= w_pwdata_next;
         r_done    <= w_done_next;
         r_rdata   <= w_rdata_next;
         r_err     <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_next = S_SETUP;
            end
         end
         S_SETUP: begin
            if (PCLKEN) begin
               w_state_next = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (w_finish) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Outputs are computed one cycle ahead and registered alongside the state.
   always_comb begin
      w_last_next    = r_last;
      w_gnt_next     = r_gnt;
      w_paddr_next   = r_paddr;
      w_pwrite_next  = r_pwrite;
      w_pwdata_next  = r_pwdata;
      w_done_next    = 2'b00;
      w_rdata_next   = r_rdata;
      w_err_next     = r_err;
      w_psel_next    = (w_state_next != S_IDLE);
      w_penable_next = (w_state_next == S_ACCESS);

      if (w_grant) begin
         w_last_next   = w_win;
         w_gnt_next    = w_win;
         w_paddr_next  = w_addr[w_win];
         w_pwrite_next = WRITE[w_win];
         w_pwdata_next = w_wdata[w_win];
      end

      if (w_complete) begin
         w_done_next  = r_gnt ? 2'b10 : 2'b01;
         w_rdata_next = r_pwrite ? '0 : PRDATA;
         w_err_next   = PSLVERR;
      end else if (w_timeout) begin
         w_done_next  = r_gnt ? 2'b10 : 2'b01;
         w_rdata_next = '0;
         w_err_next   = 1'b1;
      end
   end

   assign PSEL      = r_psel;
   assign APBACTIVE = r_psel;
   assign PENABLE   = r_penable;
   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PWDATA    = r_pwdata;
   assign DONE      = r_done;
   assign RDATA     = r_rdata;
   assign ERR       = r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transfer-level model.
module tb_apb_req_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic            HCLK = 1'b0;
   logic            HRESET;
   logic            PCLKEN;
   logic [1:0]      REQ;
   logic [2*AW-1:0] ADDR;
   logic [1:0]      WRITE;
   logic [2*DW-1:0] WDATA;
   logic [1:0]      DONE;
   logic [DW-1:0]   RDATA;
   logic            ERR;
   logic            PSEL;
   logic            PENABLE;
   logic [AW-1:0]   PADDR;
   logic            PWRITE;
   logic [DW-1:0]   PWDATA;
   logic [DW-1:0]   PRDATA;
   logic            PREADY;
   logic            PSLVERR;
   logic            APBACTIVE;

   apb_req_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN), .REQ(REQ), .ADDR(ADDR),
      .WRITE(WRITE), .WDATA(WDATA), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .APBACTIVE(APBACTIVE)
   );

   always #5 HCLK = ~HCLK;

   int errors = 0;
   int checks = 0;

   // Transfer-level model: one outstanding transfer with its owner and APB phase.
   bit            m_busy = 0;
   bit            m_in_access = 0;
   int            m_owner = 0;
   int            m_last = 1;
   int            m_access_cycles = 0;
   logic [AW-1:0] e_paddr = '0;
   logic          e_pwrite = 1'b0;
   logic [DW-1:0] e_pwdata = '0;
   logic [DW-1:0] e_rdata = '0;
   logic          e_err = 1'b0;
   logic [1:0]    e_done = 2'b00;
   logic          e_psel = 1'b0;
   logic          e_penable = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [1:0] elig;
      logic [1:0] done_n;
      int         who;
      if (HRESET) begin
         m_busy = 0; m_in_access = 0; m_last = 1;
         e_paddr = '0; e_pwrite = 0; e_pwdata = '0; e_rdata = '0; e_err = 0;
         e_done = 2'b00; e_psel = 0; e_penable = 0;
      end else begin
         elig   = REQ & ~e_done;
         done_n = 2'b00;
         if (!m_busy) begin
            if (PCLKEN && elig != 2'b00) begin
               if (elig == 2'b11) who = (m_last == 0) ? 1 : 0;
               else               who = elig[1] ? 1 : 0;
               m_owner = who; m_last = who;
               e_paddr  = ADDR[who*AW +: AW];
               e_pwrite = WRITE[who];
               e_pwdata = WDATA[who*DW +: DW];
               m_busy = 1; m_in_access = 0;
            end
         end else if (!m_in_access) begin
            if (PCLKEN) begin
               m_in_access = 1; m_access_cycles = 0;
            end
         end else begin
            m_access_cycles++;
            if (PCLKEN && PREADY) begin
               done_n[m_owner] = 1'b1;
               e_rdata = e_pwrite ? '0 : PRDATA;
               e_err   = PSLVERR;
               m_busy = 0; m_in_access = 0;
            end else if (TO_ON && m_access_cycles == TO) begin
               done_n[m_owner] = 1'b1;
               e_rdata = '0;
               e_err   = 1'b1;
               m_busy = 0; m_in_access = 0;
            end
         end
         e_done    = done_n;
         e_psel    = m_busy;
         e_penable = m_busy && m_in_access;
      end
   endtask

   // Advance one HCLK, update the model from the inputs seen at the edge, compare after it.
   task automatic cycle();
      @(posedge HCLK);
      model_step();
      #1;
      check("psel",      PSEL,      e_psel);
      check("apbactive", APBACTIVE, e_psel);
      check("penable",   PENABLE,   e_penable);
      check("paddr",     PADDR,     e_paddr);
      check("pwrite",    PWRITE,    e_pwrite);
      check("pwdata",    PWDATA,    e_pwdata);
      check("done",      DONE,      e_done);
      check("rdata",     RDATA,     e_rdata);
      check("err",       ERR,       e_err);
   endtask

   task automatic set_req(input int i, input bit r, input logic [AW-1:0] a,
                          input bit w, input logic [DW-1:0] d);
      REQ[i]           = r;
      ADDR[i*AW +: AW] = a;
      WRITE[i]         = w;
      WDATA[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      HRESET = 1'b1;
      cycle();
      HRESET = 1'b0;
   endtask

   initial begin
      int  k, acc, cnt;
      bit  got;
      HRESET = 1'b1; PCLKEN = 1'b1; REQ = '0; ADDR = '0; WRITE = '0; WDATA = '0;
      PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;

      // Reset state
      do_reset();
      check("rst_psel",  PSEL, 1'b0);
      check("rst_done",  DONE, 2'b00);
      check("rst_paddr", PADDR, 16'h0000);
      check("rst_rdata", RDATA, 32'h0);

      // Single read
      set_req(0, 1, 16'h0010, 0, 32'h0);
      PRDATA = 32'hDEADBEEF;
      cycle();
      check("rd_c1_psel", PSEL, 1'b1);
      check("rd_c1_pen",  PENABLE, 1'b0);
      cycle();
      check("rd_c2_pen",  PENABLE, 1'b1);
      check("rd_c2_paddr", PADDR, 16'h0010);
      cycle();
      check("rd_c3_done",  DONE, 2'b01);
      check("rd_c3_rdata", RDATA, 32'hDEADBEEF);
      check("rd_c3_err",   ERR, 1'b0);
      check("rd_c3_psel",  PSEL, 1'b0);
      REQ = 2'b00;
      cycle();

      // Contention: grant order must alternate starting at requester 0
      do_reset();
      set_req(0, 1, 16'h1000, 0, 32'h0);
      set_req(1, 1, 16'h2000, 0, 32'h0);
      k = 0;
      for (int n = 0; n < 40 && k < 4; n++) begin
         cycle();
         if (DONE != 2'b00) begin
            check("rr_order", DONE, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_paddr", PADDR, (k % 2 == 0) ? 16'h1000 : 16'h2000);
            k++;
         end
      end
      check("rr_count", k, 4);
      REQ = 2'b00;
      cycle(); cycle();

      // Wait states with slave error on a write
      set_req(0, 1, 16'h0040, 1, 32'hA5A50001);
      PREADY = 1'b0; PSLVERR = 1'b1;
      acc = 0; got = 0;
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (DONE != 2'b00) begin got = 1; break; end
         if (PENABLE) begin
            acc++;
            check("ws_paddr",  PADDR, 16'h0040);
            check("ws_pwdata", PWDATA, 32'hA5A50001);
         end
         PREADY = (acc == 5);
      end
      check("ws_got_done", got, 1'b1);
      check("ws_access_len", acc, 5);
      check("ws_done", DONE, 2'b01);
      check("ws_err",  ERR, 1'b1);
      check("ws_rdata", RDATA, 32'h0);
      REQ = 2'b00; PREADY = 1'b1; PSLVERR = 1'b0;
      cycle();

      // PCLKEN toggling during a write from requester 1
      set_req(1, 1, 16'h0200, 1, 32'h12345678);
      PCLKEN = 1'b1;
      cnt = 0; got = 0;
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (DONE != 2'b00) begin got = 1; break; end
         if (PSEL) begin
            cnt++;
            check("ce_pwdata", PWDATA, 32'h12345678);
            check("ce_pwrite", PWRITE, 1'b1);
         end
         PCLKEN = ~PCLKEN;
      end
      check("ce_got_done", got, 1'b1);
      check("ce_psel_cycles", cnt, 4);
      check("ce_done", DONE, 2'b10);
      PCLKEN = 1'b1; REQ = 2'b00;
      cycle();

      // Reset during ACCESS aborts; requester 0 leads afterwards
      set_req(0, 1, 16'h0300, 0, 32'h0);
      PREADY = 1'b0;
      cycle(); cycle();
      check("ra_in_access", PENABLE, 1'b1);
      HRESET = 1'b1;
      cycle();
      HRESET = 1'b0;
      check("ra_psel", PSEL, 1'b0);
      check("ra_done", DONE, 2'b00);
      set_req(1, 1, 16'h0400, 0, 32'h0);
      PREADY = 1'b1;
      got = 0;
      for (int n = 0; n < 10; n++) begin
         cycle();
         if (DONE != 2'b00) begin got = 1; break; end
      end
      check("ra_got_done", got, 1'b1);
      check("ra_first_grant", DONE, 2'b01);
      REQ = 2'b00;
      cycle(); cycle();

      // Slave that never becomes ready
      set_req(0, 1, 16'h0500, 0, 32'h0);
      PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
`ifdef APB_TIMEOUT_EN
      acc = 0; got = 0;
      for (int n = 0; n < 40; n++) begin
         cycle();
         if (DONE != 2'b00) begin got = 1; break; end
         if (PENABLE) acc++;
      end
      check("to_got_done", got, 1'b1);
      check("to_access_len", acc, TO);
      check("to_err", ERR, 1'b1);
      check("to_rdata", RDATA, 32'h0);
      REQ = 2'b00;
      cycle();
`else
      for (int n = 0; n < 40; n++) cycle();
      check("stall_psel", PSEL, 1'b1);
      check("stall_pen",  PENABLE, 1'b1);
      check("stall_done", DONE, 2'b00);
      REQ = 2'b00;
      do_reset();
`endif
      PREADY = 1'b1;

      // Randomized traffic; requesters hold their request until their DONE
      for (int n = 0; n < 3000; n++) begin
         PCLKEN  = ($urandom_range(0, 3) != 0);
         PREADY  = ($urandom_range(0, 2) != 0);
         PSLVERR = ($urandom_range(0, 3) == 0);
         PRDATA  = $urandom;
         HRESET  = ($urandom_range(0, 299) == 0);
         for (int i = 0; i < 2; i++) begin
            if (REQ[i] && DONE[i]) REQ[i] = 1'b0;
            if (!REQ[i] && $urandom_range(0, 2) == 0)
               set_req(i, 1, AW'($urandom), 1'($urandom), $urandom);
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end
endmodule
